// File: rtl/incubator_pkg.sv
// Shared types and default thresholds for the incubator temperature controller.
package incubator_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HEAT  = 3'd1,
      COOL1 = 3'd2,
      COOL2 = 3'd3,
      COOL3 = 3'd4
   } state_t;

   // Actuator command bundle sent to the heater/cooler drivers.
   typedef struct packed {
      logic       heater;
      logic       cooler;
      logic [3:0] crs;
   } act_t;

   localparam int         T_HEAT_ON_DEF  = 15;
   localparam int         T_HEAT_OFF_DEF = 30;
   localparam int         T_COOL_ON_DEF  = 35;
   localparam int         T_COOL_OFF_DEF = 25;
   localparam int         T_FAST_DEF     = 40;
   localparam int         T_FASTER_DEF   = 45;
   localparam logic [3:0] CRS_1_DEF      = 4'd4;
   localparam logic [3:0] CRS_2_DEF      = 4'd6;
   localparam logic [3:0] CRS_3_DEF      = 4'd8;

endpackage

// File: rtl/incubator_if.sv
// Sensor-to-actuator bundle: signed temperature in, actuator commands out.
interface incubator_if;
   import incubator_pkg::*;

   logic signed [7:0] temperature;
   act_t              act;

   // master: sensor side driving temperature; slave: the controller.
   modport master (output temperature, input act);
   modport slave  (input temperature, output act);

endinterface

// File: rtl/incubator_core.sv
// Moore FSM with hysteresis mapping chamber temperature to heater/cooler commands.
// Latency: one clock from sampled temperature to updated actuator outputs.
// Backpressure: none; temperature is sampled unconditionally every clock.
module incubator_core
   import incubator_pkg::*;
#(
   parameter int         T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter int         T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter int         T_COOL_ON  = T_COOL_ON_DEF,
   parameter int         T_COOL_OFF = T_COOL_OFF_DEF,
   parameter int         T_FAST     = T_FAST_DEF,
   parameter int         T_FASTER   = T_FASTER_DEF,
   parameter logic [3:0] CRS_1      = CRS_1_DEF,
   parameter logic [3:0] CRS_2      = CRS_2_DEF,
   parameter logic [3:0] CRS_3      = CRS_3_DEF
) (
   input  logic      clk,
   input  logic      reset,
   incubator_if.slave bus
);

   state_t state;
   state_t nxt;

   // Stop-to-IDLE wins over speed changes; up-steps win over down-steps.
   function automatic state_t next_state(input state_t s, input logic signed [7:0] t);
      state_t n;
      n = s;
      case (s)
         IDLE: begin
            if (t < T_HEAT_ON)       n = HEAT;
            else if (t > T_COOL_ON)  n = COOL1;
         end
         HEAT: begin
            if (t >= T_HEAT_OFF)     n = IDLE;
         end
         COOL1: begin
            if (t < T_COOL_OFF)      n = IDLE;
            else if (t > T_FAST)     n = COOL2;
         end
         COOL2: begin
            if (t < T_COOL_OFF)      n = IDLE;
            else if (t > T_FASTER)   n = COOL3;
            else if (t < T_COOL_ON)  n = COOL1;
         end
         COOL3: begin
            if (t < T_COOL_OFF)      n = IDLE;
            else if (t < T_FAST)     n = COOL2;
         end
         default:                    n = IDLE;
      endcase
      return n;
   endfunction

   function automatic act_t decode(input state_t s);
      act_t a;
      a = '0;
      case (s)
         HEAT:    a.heater = 1'b1;
         COOL1:   begin a.cooler = 1'b1; a.crs = CRS_1; end
         COOL2:   begin a.cooler = 1'b1; a.crs = CRS_2; end
         COOL3:   begin a.cooler = 1'b1; a.crs = CRS_3; end
         default: a = '0;
      endcase
      return a;
   endfunction

   always_comb begin
      nxt = next_state(state, bus.temperature);
   end

   // Outputs are registered from the next state so they always equal decode(state).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bus.act <= '0;
      end else begin
         state   <= nxt;
         bus.act <= decode(nxt);
      end
   end

endmodule

// File: rtl/incubator.sv
// Incubator chamber temperature controller: heater, cooler and cooler speed.
// Latency: outputs reflect a temperature one rising edge after it is sampled.
// Backpressure: none; free-running sample every clock, async active-low reset.
module incubator
   import incubator_pkg::*;
#(
   parameter int         T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter int         T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter int         T_COOL_ON  = T_COOL_ON_DEF,
   parameter int         T_COOL_OFF = T_COOL_OFF_DEF,
   parameter int         T_FAST     = T_FAST_DEF,
   parameter int         T_FASTER   = T_FASTER_DEF,
   parameter logic [3:0] CRS_1      = CRS_1_DEF,
   parameter logic [3:0] CRS_2      = CRS_2_DEF,
   parameter logic [3:0] CRS_3      = CRS_3_DEF
) (
   input  logic signed [7:0] temperature,
   input  logic              clk,
   input  logic              reset,
   output logic              heater,
   output logic              cooler,
   output logic [3:0]        crs
);

   incubator_if bus ();

   assign bus.temperature = temperature;
   assign heater          = bus.act.heater;
   assign cooler          = bus.act.cooler;
   assign crs             = bus.act.crs;

   incubator_core #(
      .T_HEAT_ON  (T_HEAT_ON),
      .T_HEAT_OFF (T_HEAT_OFF),
      .T_COOL_ON  (T_COOL_ON),
      .T_COOL_OFF (T_COOL_OFF),
      .T_FAST     (T_FAST),
      .T_FASTER   (T_FASTER),
      .CRS_1      (CRS_1),
      .CRS_2      (CRS_2),
      .CRS_3      (CRS_3)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

endmodule

// File: tb/tb_incubator.sv
// Self-checking bench for incubator: directed vector table, reset corner cases, random vs model.
module tb_incubator;
   import incubator_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       heater;
   logic       cooler;
   logic [3:0] crs;

   int checks = 0;
   int errors = 0;
   // Reference level: -1 heating, 0 idle, 1..3 cooling speed step.
   int lvl = 0;

   incubator_if sens ();

   always #10 clk = ~clk;

   incubator dut (
      .temperature (sens.temperature),
      .clk         (clk),
      .reset       (reset),
      .heater      (heater),
      .cooler      (cooler),
      .crs         (crs)
   );

   assign sens.act = {heater, cooler, crs};

   typedef struct {
      int         temp;
      logic       h;
      logic       c;
      logic [3:0] s;
      string      name;
   } vec_t;

   vec_t tbl[$];

   // Per cooling step: threshold to climb above, threshold to fall below.
   int up_thr[4]   = '{0, 40, 45, 0};
   int down_thr[4] = '{0, 0, 35, 40};

   function automatic int model_next(input int l, input int t);
      if (l == 0) begin
         if (t < 15) return -1;
         if (t > 35) return 1;
         return 0;
      end
      if (l < 0) return (t >= 30) ? 0 : -1;
      if (t < 25) return 0;
      if (l < 3 && t > up_thr[l]) return l + 1;
      if (l > 1 && t < down_thr[l]) return l - 1;
      return l;
   endfunction

   function automatic logic [5:0] model_out(input int l);
      logic [3:0] speed;
      speed = (l > 0) ? 4'(2 + 2 * l) : 4'd0;
      return {l < 0, l > 0, speed};
   endfunction

   task automatic check(input string name, input logic [5:0] exp);
      checks++;
      if ({heater, cooler, crs} !== exp) begin
         errors++;
         $display("FAIL %s: got heater=%b cooler=%b crs=%0d, want heater=%b cooler=%b crs=%0d",
                  name, heater, cooler, crs, exp[5], exp[4], exp[3:0]);
      end
   endtask

   // Drive one temperature, let one rising edge sample it, then check.
   task automatic run(input int t, input bit use_exp, input logic [5:0] exp, input string name);
      sens.temperature = 8'(t);
      @(posedge clk);
      #1;
      lvl = model_next(lvl, t);
      if (use_exp) check(name, exp);
      else         check(name, model_out(lvl));
      @(negedge clk);
   endtask

   task automatic reset_pulse(input string name);
      #3 reset = 1'b0;
      lvl = 0;
      #1 check(name, 6'b0);
      #2 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      sens.temperature = 8'sd20;
      #5;
      check("reset_hold", 6'b0);
      #15 reset = 1'b1;
      run(20, 1'b1, 6'b0, "release_idle");

      tbl.push_back(vec_t'{40,   1'b0, 1'b1, 4'd4, "idle_hot_cool1"});
      tbl.push_back(vec_t'{20,   1'b0, 1'b0, 4'd0, "cool1_stop"});
      tbl.push_back(vec_t'{45,   1'b0, 1'b1, 4'd4, "idle_45_cool1"});
      tbl.push_back(vec_t'{50,   1'b0, 1'b1, 4'd6, "climb_cool2"});
      tbl.push_back(vec_t'{50,   1'b0, 1'b1, 4'd8, "climb_cool3"});
      tbl.push_back(vec_t'{20,   1'b0, 1'b0, 4'd0, "cool3_stop"});
      tbl.push_back(vec_t'{15,   1'b0, 1'b0, 4'd0, "heat_on_eq"});
      tbl.push_back(vec_t'{10,   1'b1, 1'b0, 4'd0, "idle_heat"});
      tbl.push_back(vec_t'{29,   1'b1, 1'b0, 4'd0, "heat_hold"});
      tbl.push_back(vec_t'{30,   1'b0, 1'b0, 4'd0, "heat_off_eq"});
      tbl.push_back(vec_t'{35,   1'b0, 1'b0, 4'd0, "cool_on_eq"});
      tbl.push_back(vec_t'{36,   1'b0, 1'b1, 4'd4, "cool_on_36"});
      tbl.push_back(vec_t'{40,   1'b0, 1'b1, 4'd4, "fast_eq"});
      tbl.push_back(vec_t'{25,   1'b0, 1'b1, 4'd4, "cool_off_eq"});
      tbl.push_back(vec_t'{41,   1'b0, 1'b1, 4'd6, "cool1_up"});
      tbl.push_back(vec_t'{45,   1'b0, 1'b1, 4'd6, "faster_eq"});
      tbl.push_back(vec_t'{35,   1'b0, 1'b1, 4'd6, "cool2_down_eq"});
      tbl.push_back(vec_t'{34,   1'b0, 1'b1, 4'd4, "cool2_down"});
      tbl.push_back(vec_t'{24,   1'b0, 1'b0, 4'd0, "cool1_off"});
      tbl.push_back(vec_t'{-128, 1'b1, 1'b0, 4'd0, "neg_min_heat"});
      tbl.push_back(vec_t'{40,   1'b0, 1'b0, 4'd0, "heat_no_direct_cool"});
      tbl.push_back(vec_t'{127,  1'b0, 1'b1, 4'd4, "max_cool1"});
      tbl.push_back(vec_t'{127,  1'b0, 1'b1, 4'd6, "max_cool2"});
      tbl.push_back(vec_t'{127,  1'b0, 1'b1, 4'd8, "max_cool3"});
      tbl.push_back(vec_t'{42,   1'b0, 1'b1, 4'd8, "cool3_hold_42"});
      tbl.push_back(vec_t'{40,   1'b0, 1'b1, 4'd8, "cool3_fast_eq"});
      tbl.push_back(vec_t'{38,   1'b0, 1'b1, 4'd6, "cool3_down"});
      tbl.push_back(vec_t'{38,   1'b0, 1'b1, 4'd6, "cool2_hold_38"});
      tbl.push_back(vec_t'{34,   1'b0, 1'b1, 4'd4, "hyst_cool1"});
      tbl.push_back(vec_t'{100,  1'b0, 1'b1, 4'd6, "cool1_to_cool2"});
      tbl.push_back(vec_t'{24,   1'b0, 1'b0, 4'd0, "cool2_stop"});

      foreach (tbl[i]) run(tbl[i].temp, 1'b1, {tbl[i].h, tbl[i].c, tbl[i].s}, tbl[i].name);

      // Async reset while heating, then resume.
      run(10, 1'b1, 6'b10_0000, "pre_reset_heat");
      reset_pulse("reset_mid_heat");
      run(10, 1'b1, 6'b10_0000, "reheat_after_reset");
      run(40, 1'b1, 6'b0, "heat_to_idle_40");

      // Async reset while cooling at top speed.
      run(60, 1'b1, 6'b01_0100, "pre_reset_c1");
      run(60, 1'b1, 6'b01_0110, "pre_reset_c2");
      run(60, 1'b1, 6'b01_1000, "pre_reset_c3");
      reset_pulse("reset_mid_cool");
      run(30, 1'b1, 6'b0, "idle_after_cool_reset");

      for (int i = 0; i < 2000; i++) begin
         int t;
         if ($urandom_range(0, 9) == 0) t = int'($urandom_range(0, 255)) - 128;
         else                           t = int'($urandom_range(5, 55));
         if ($urandom_range(0, 99) == 0) reset_pulse("rand_reset");
         run(t, 1'b0, 6'b0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
